// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with 2-FF input sync, optional parity and frame/parity error flags
module uart_rx #(
  parameter int DATA_BITS    = 8,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int OVERSAMPLING = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);
  localparam int CW = $clog2(OVERSAMPLING);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLING / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLING - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic rx_m, rx_s, par, par_n, done, par_bad;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  assign busy = (state != IDLE);
  assign par_bad = par ^ (^sh) ^ PARITY_ODD;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      par        <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      sh         <= sh_n;
      par        <= par_n;
      rx_valid   <= done;
      frame_err  <= done & ~rx_s;
      parity_err <= done & PARITY_EN & par_bad;
      if (done) rx_data <= sh;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    par_n   = par;
    done    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: if (tick_16x) begin
        cnt_n = (cnt == HALF) ? '0 : cnt + 1'b1;
        idx_n = '0;
        if (cnt == HALF) state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (tick_16x) begin
        cnt_n = (cnt == LAST) ? '0 : cnt + 1'b1;
        if (cnt == LAST) begin
          sh_n  = {rx_s, sh[DATA_BITS-1:1]};
          idx_n = idx + 1'b1;
          if (idx == IDX_LAST) state_n = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: if (tick_16x) begin
        cnt_n = (cnt == LAST) ? '0 : cnt + 1'b1;
        if (cnt == LAST) begin
          par_n   = rx_s;
          state_n = STOP;
        end
      end
      STOP: if (tick_16x) begin
        cnt_n = (cnt == LAST) ? '0 : cnt + 1'b1;
        if (cnt == LAST) begin
          done    = 1'b1;
          state_n = rx_s ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into an 8N1 and an 8E1 receiver, checked against a per-receiver expectation queue
module tb_uart_rx;
  localparam int BT = 64;
  logic clk = 1'b0, rst_n = 1'b0, rx_a = 1'b1, rx_b = 1'b1;
  logic [1:0] tdiv = '0;
  logic tick;
  logic [7:0] data_a, data_b, d;
  logic val_a, val_b, fe_a, fe_b, pe_a, pe_b, busy_a, busy_b;
  logic [9:0] ea, eb;
  logic [9:0] q_a[$], q_b[$];
  int total = 0, passed = 0, vcnt_a = 0, vcnt_b = 0, v0;
  always #5 clk = ~clk;
  always @(posedge clk) tdiv <= tdiv + 2'd1;
  assign tick = (tdiv == 2'd3);
  uart_rx dut_a (
    .clk(clk), .rst_n(rst_n), .tick_16x(tick), .rx(rx_a), .rx_data(data_a),
    .rx_valid(val_a), .frame_err(fe_a), .parity_err(pe_a), .busy(busy_a)
  );
  uart_rx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick_16x(tick), .rx(rx_b), .rx_data(data_b),
    .rx_valid(val_b), .frame_err(fe_b), .parity_err(pe_b), .busy(busy_b)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic hold(input bit b, input logic v, input int n);
    if (b) rx_b = v; else rx_a = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic frame(input bit b, input logic [7:0] x, input int par, input logic stop);
    hold(b, 1'b0, BT);
    for (int i = 0; i < 8; i++) hold(b, x[i], BT);
    if (par >= 0) hold(b, par[0], BT);
    hold(b, stop, BT);
  endtask
  always @(negedge clk) if (val_a) begin
    vcnt_a++;
    if (q_a.size() == 0) chk("a_spurious_valid", 32'(val_a), 32'd0);
    else begin
      ea = q_a.pop_front();
      chk("a_data", 32'(data_a), 32'(ea[7:0]));
      chk("a_frame_err", 32'(fe_a), 32'(ea[9]));
      chk("a_parity_err", 32'(pe_a), 32'(ea[8]));
    end
  end
  always @(negedge clk) if (val_b) begin
    vcnt_b++;
    if (q_b.size() == 0) chk("b_spurious_valid", 32'(val_b), 32'd0);
    else begin
      eb = q_b.pop_front();
      chk("b_data", 32'(data_b), 32'(eb[7:0]));
      chk("b_frame_err", 32'(fe_b), 32'(eb[9]));
      chk("b_parity_err", 32'(pe_b), 32'(eb[8]));
    end
  end
  initial begin
    repeat (4) @(negedge clk);
    chk("rst_valid", 32'(val_a), 32'd0);
    chk("rst_data", 32'(data_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_flags", 32'({fe_a, pe_a, fe_b, pe_b}), 32'd0);
    rst_n = 1'b1;
    hold(0, 1'b1, BT);
    // 0x55 with a busy probe during the first data bit
    q_a.push_back({2'b00, 8'h55});
    d = 8'h55;
    hold(0, 1'b0, BT);
    chk("t1_busy_mid", 32'(busy_a), 32'd1);
    for (int i = 0; i < 8; i++) hold(0, d[i], BT);
    hold(0, 1'b1, BT);
    chk("t1_busy_fall", 32'(busy_a), 32'd0);
    chk("t1_count", 32'(vcnt_a), 32'd1);
    // back-to-back frames, no idle gap
    q_a.push_back({2'b00, 8'hA5});
    frame(0, 8'hA5, -1, 1'b1);
    q_a.push_back({2'b00, 8'h3C});
    frame(0, 8'h3C, -1, 1'b1);
    chk("t2_count", 32'(vcnt_a), 32'd3);
    hold(0, 1'b1, 2 * BT);
    chk("t2_data_held", 32'(data_a), 32'h3C);
    // short low glitch rejected at mid start bit
    v0 = vcnt_a;
    hold(0, 1'b0, 16);
    hold(0, 1'b1, BT);
    chk("t3_no_valid", 32'(vcnt_a), 32'(v0));
    chk("t3_busy", 32'(busy_a), 32'd0);
    // bad stop bit followed by a held-low break, then a clean frame
    q_a.push_back({2'b10, 8'hFF});
    frame(0, 8'hFF, -1, 1'b0);
    hold(0, 1'b0, 2 * BT);
    chk("t4_busy_break", 32'(busy_a), 32'd1);
    hold(0, 1'b1, BT);
    q_a.push_back({2'b00, 8'h12});
    frame(0, 8'h12, -1, 1'b1);
    chk("t4_count", 32'(vcnt_a), 32'd5);
    // even parity: 0x07 needs parity bit 1
    q_b.push_back({2'b00, 8'h07});
    frame(1, 8'h07, 1, 1'b1);
    q_b.push_back({2'b01, 8'h07});
    frame(1, 8'h07, 0, 1'b1);
    chk("t5_count", 32'(vcnt_b), 32'd2);
    // reset in data bit 4 of 0xF0
    v0 = vcnt_a;
    d = 8'hF0;
    hold(0, 1'b0, BT);
    for (int i = 0; i < 4; i++) hold(0, d[i], BT);
    hold(0, 1'b1, BT / 2);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_rst_busy", 32'(busy_a), 32'd0);
    chk("t6_rst_data", 32'(data_a), 32'd0);
    chk("t6_rst_valid", 32'(val_a), 32'd0);
    rst_n = 1'b1;
    hold(0, 1'b1, 5 * BT);
    chk("t6_no_valid", 32'(vcnt_a), 32'(v0));
    q_a.push_back({2'b00, 8'h81});
    frame(0, 8'h81, -1, 1'b1);
    hold(0, 1'b1, BT);
    chk("q_a_drained", 32'(q_a.size()), 32'd0);
    chk("q_b_drained", 32'(q_b.size()), 32'd0);
    chk("final_busy", 32'({busy_a, busy_b}), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
